// File: rtl/tile_interact_pkg.sv
// ---------------------------------------------------------------------------
// tile_interact_pkg
//   Shared definitions for the tile-interaction engine: tile codes, the
//   potion heal amount and the engine's FSM state encoding.
// ---------------------------------------------------------------------------
package tile_interact_pkg;

  localparam int TILE_FLOOR  = 0;
  localparam int TILE_WALL   = 1;
  localparam int TILE_KEY    = 2;
  localparam int TILE_DOOR   = 3;
  localparam int TILE_POTION = 4;

  localparam int POTION_HEAL = 20;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_COMMIT  = 2'd3
  } state_t;

endpackage

// File: rtl/tile_interact_arb_resolve.sv
// ---------------------------------------------------------------------------
// tile_rule_resolve
//   Purely combinational interaction rules for one move onto one tile.
//   Ports:
//     tile              tile id currently at the target
//     cur_x/cur_y       actor position before the move
//     tgt_x/tgt_y       requested target position
//     key/health        actor key count and health before the move
//     accept            move allowed
//     goto_x/goto_y     resulting position (target if accepted, else current)
//     key_next          key count after the move (saturating increment)
//     health_next       health after the move (saturating add)
//     new_tile          tile id to leave at the target
// ---------------------------------------------------------------------------
module tile_rule_resolve
  import tile_interact_pkg::*;
#(
  parameter int COORD_W  = 4,
  parameter int TILE_W   = 16,
  parameter int KEY_W    = 4,
  parameter int HEALTH_W = 8
) (
  input  logic [TILE_W-1:0]   tile,
  input  logic [COORD_W-1:0]  cur_x,
  input  logic [COORD_W-1:0]  cur_y,
  input  logic [COORD_W-1:0]  tgt_x,
  input  logic [COORD_W-1:0]  tgt_y,
  input  logic [KEY_W-1:0]    key,
  input  logic [HEALTH_W-1:0] health,
  output logic                accept,
  output logic [COORD_W-1:0]  goto_x,
  output logic [COORD_W-1:0]  goto_y,
  output logic [KEY_W-1:0]    key_next,
  output logic [HEALTH_W-1:0] health_next,
  output logic [TILE_W-1:0]   new_tile
);

  // One extra bit catches the carry of the potion add for saturation.
  logic [HEALTH_W:0] heal_sum;
  assign heal_sum = {1'b0, health} + (HEALTH_W+1)'(POTION_HEAL);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    accept      = 1'b0;
    key_next    = key;
    health_next = health;
    new_tile    = tile;
    case (tile)
      TILE_W'(TILE_FLOOR): accept = 1'b1;
      TILE_W'(TILE_KEY): begin
        accept   = 1'b1;
        key_next = (&key) ? key : key + 1'b1;
        new_tile = TILE_W'(TILE_FLOOR);
      end
      TILE_W'(TILE_DOOR): begin
        if (key != '0) begin
          accept   = 1'b1;
          key_next = key - 1'b1;
          new_tile = TILE_W'(TILE_FLOOR);
        end
      end
      TILE_W'(TILE_POTION): begin
        accept      = 1'b1;
        health_next = heal_sum[HEALTH_W] ? '1 : heal_sum[HEALTH_W-1:0];
        new_tile    = TILE_W'(TILE_FLOOR);
      end
      default: ;  // walls and unknown ids reject with no side effects
    endcase
  end

  assign goto_x = accept ? tgt_x : cur_x;
  assign goto_y = accept ? tgt_y : cur_y;

endmodule

// File: rtl/tile_interact_arb.sv
// ---------------------------------------------------------------------------
// tile_interact_arb
//   Round-robin arbiter plus interaction engine: grants one actor move
//   request at a time, reads the target tile from the map BRAM, resolves
//   the interaction, writes the changed tile back and emits one response.
//   Optional macro TILE_INTERACT_BOUNDS_CHECK_EN: off-map targets skip the
//   RAM access and are rejected two cycles after the handshake.
//   Ports:
//     clk, rst                   clock, asynchronous active-high reset
//     req_valid/req_ready        per-channel request, one-hot grant
//     req_x/req_y, cur_x/cur_y   packed target / current positions
//     key_num, health            packed per-channel actor state
//     resp_*                     one-cycle response strobe and payload
//     ram_addr/ram_rdata         map read port (read latency RAM_LAT)
//     ram_we/ram_wdata           one-cycle tile write-back
// ---------------------------------------------------------------------------
module tile_interact_arb
  import tile_interact_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int COORD_W  = 4,
  parameter int MAP_W    = 16,
  parameter int MAP_H    = 16,
  parameter int ADDR_W   = 19,
  parameter int TILE_W   = 16,
  parameter int RAM_LAT  = 1,
  parameter int KEY_W    = 4,
  parameter int HEALTH_W = 8,
  localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          req_valid,
  output logic [NCH-1:0]          req_ready,
  input  logic [NCH*COORD_W-1:0]  req_x,
  input  logic [NCH*COORD_W-1:0]  req_y,
  input  logic [NCH*COORD_W-1:0]  cur_x,
  input  logic [NCH*COORD_W-1:0]  cur_y,
  input  logic [NCH*KEY_W-1:0]    key_num,
  input  logic [NCH*HEALTH_W-1:0] health,
  output logic                    resp_valid,
  output logic [CH_W-1:0]         resp_ch,
  output logic                    resp_accept,
  output logic [COORD_W-1:0]      resp_x,
  output logic [COORD_W-1:0]      resp_y,
  output logic [KEY_W-1:0]        resp_key,
  output logic [HEALTH_W-1:0]     resp_health,
  output logic [ADDR_W-1:0]       ram_addr,
  input  logic [TILE_W-1:0]       ram_rdata,
  output logic                    ram_we,
  output logic [TILE_W-1:0]       ram_wdata
);

  localparam int CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
`ifdef TILE_INTERACT_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  state_t              state_q, state_d;
  logic [CH_W-1:0]     rr_q, ch_q;
  logic [COORD_W-1:0]  tgt_x_q, tgt_y_q, cur_x_q, cur_y_q;
  logic [KEY_W-1:0]    key_q;
  logic [HEALTH_W-1:0] health_q;
  logic [TILE_W-1:0]   tile_q;
  logic [CNT_W-1:0]    wait_q;
  logic                oob_q;

  // ---- round-robin grant: first valid channel after the last served one
  logic [NCH-1:0]  gnt;
  logic [CH_W-1:0] gnt_ch;
  logic            gnt_found;

  always_comb begin
    gnt       = '0;
    gnt_ch    = '0;
    gnt_found = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      if (!gnt_found && req_valid[(int'(rr_q) + i) % NCH]) begin
        gnt_found = 1'b1;
        gnt_ch    = CH_W'((int'(rr_q) + i) % NCH);
      end
    end
    if (gnt_found) gnt[gnt_ch] = 1'b1;
  end

  // Ready is withheld during the response cycle so back-to-back requests
  // are spaced RAM_LAT+4 cycles apart.
  logic can_accept, handshake;
  assign can_accept = (state_q == ST_IDLE) && !resp_valid && !rst;
  assign req_ready  = can_accept ? gnt : '0;
  assign handshake  = can_accept && gnt_found;

  // ---- fields of the granted channel
  logic [COORD_W-1:0]  sel_rx, sel_ry, sel_cx, sel_cy;
  logic [KEY_W-1:0]    sel_key;
  logic [HEALTH_W-1:0] sel_health;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_oob;

  assign sel_rx     = req_x[gnt_ch*COORD_W +: COORD_W];
  assign sel_ry     = req_y[gnt_ch*COORD_W +: COORD_W];
  assign sel_cx     = cur_x[gnt_ch*COORD_W +: COORD_W];
  assign sel_cy     = cur_y[gnt_ch*COORD_W +: COORD_W];
  assign sel_key    = key_num[gnt_ch*KEY_W +: KEY_W];
  assign sel_health = health[gnt_ch*HEALTH_W +: HEALTH_W];
  // Address is formed at full ADDR_W so y*MAP_W cannot wrap.
  assign sel_addr   = ADDR_W'(sel_ry) * ADDR_W'(MAP_W) + ADDR_W'(sel_rx);
  assign sel_oob    = BOUNDS_EN &&
                      ((int'(sel_rx) >= MAP_W) || (int'(sel_ry) >= MAP_H));

  // ---- resolver on the latched request
  logic                res_accept;
  logic [COORD_W-1:0]  res_x, res_y;
  logic [KEY_W-1:0]    res_key;
  logic [HEALTH_W-1:0] res_health;
  logic [TILE_W-1:0]   res_tile;

  tile_rule_resolve #(
    .COORD_W (COORD_W),
    .TILE_W  (TILE_W),
    .KEY_W   (KEY_W),
    .HEALTH_W(HEALTH_W)
  ) u_resolve (
    .tile       (tile_q),
    .cur_x      (cur_x_q),
    .cur_y      (cur_y_q),
    .tgt_x      (tgt_x_q),
    .tgt_y      (tgt_y_q),
    .key        (key_q),
    .health     (health_q),
    .accept     (res_accept),
    .goto_x     (res_x),
    .goto_y     (res_y),
    .key_next   (res_key),
    .health_next(res_health),
    .new_tile   (res_tile)
  );

  // ---- FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (handshake) state_d = sel_oob ? ST_COMMIT : ST_WAIT;
      ST_WAIT:    if (wait_q == '0) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_COMMIT;
      ST_COMMIT:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q        <= '0;
      ch_q        <= '0;
      tgt_x_q     <= '0;
      tgt_y_q     <= '0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      key_q       <= '0;
      health_q    <= '0;
      tile_q      <= '0;
      wait_q      <= '0;
      oob_q       <= 1'b0;
      resp_valid  <= 1'b0;
      resp_ch     <= '0;
      resp_accept <= 1'b0;
      resp_x      <= '0;
      resp_y      <= '0;
      resp_key    <= '0;
      resp_health <= '0;
      ram_addr    <= '0;
      ram_we      <= 1'b0;
      ram_wdata   <= '0;
    end else begin
      resp_valid <= 1'b0;
      ram_we     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (handshake) begin
            ch_q     <= gnt_ch;
            tgt_x_q  <= sel_rx;
            tgt_y_q  <= sel_ry;
            cur_x_q  <= sel_cx;
            cur_y_q  <= sel_cy;
            key_q    <= sel_key;
            health_q <= sel_health;
            oob_q    <= sel_oob;
            wait_q   <= CNT_W'(RAM_LAT - 1);
            if (!sel_oob) ram_addr <= sel_addr;
          end
        end
        ST_WAIT: begin
          if (wait_q != '0) wait_q <= wait_q - 1'b1;
        end
        ST_CAPTURE: tile_q <= ram_rdata;
        ST_COMMIT: begin
          resp_valid <= 1'b1;
          resp_ch    <= ch_q;
          rr_q       <= ch_q;
          if (oob_q) begin
            resp_accept <= 1'b0;
            resp_x      <= cur_x_q;
            resp_y      <= cur_y_q;
            resp_key    <= key_q;
            resp_health <= health_q;
            ram_wdata   <= tile_q;
          end else begin
            resp_accept <= res_accept;
            resp_x      <= res_x;
            resp_y      <= res_y;
            resp_key    <= res_key;
            resp_health <= res_health;
            ram_wdata   <= res_tile;
            // Only a real change is written; rejects never alter the tile.
            ram_we      <= res_accept && (res_tile != tile_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_interact_arb.sv
// ---------------------------------------------------------------------------
// tb_tile_interact_arb
//   Directed bench for tile_interact_arb with a behavioural map BRAM, a
//   request-level reference model checked every cycle, and literal
//   expectations for the hand-worked scenarios.
// ---------------------------------------------------------------------------
module tb_tile_interact_arb;

  localparam int NCH = 2, COORD_W = 4, MAP_W = 16, MAP_H = 16, ADDR_W = 19;
  localparam int TILE_W = 16, RAM_LAT = 1, KEY_W = 4, HEALTH_W = 8;
  localparam int KEY_MAX = (1 << KEY_W) - 1;
  localparam int HP_MAX  = (1 << HEALTH_W) - 1;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NCH-1:0]          req_valid = '0;
  logic [NCH-1:0]          req_ready;
  logic [NCH*COORD_W-1:0]  req_x = '0, req_y = '0, cur_x = '0, cur_y = '0;
  logic [NCH*KEY_W-1:0]    key_num = '0;
  logic [NCH*HEALTH_W-1:0] health = '0;
  logic                    resp_valid, resp_accept, ram_we;
  logic [0:0]              resp_ch;
  logic [COORD_W-1:0]      resp_x, resp_y;
  logic [KEY_W-1:0]        resp_key;
  logic [HEALTH_W-1:0]     resp_health;
  logic [ADDR_W-1:0]       ram_addr;
  logic [TILE_W-1:0]       ram_rdata, ram_wdata;

  tile_interact_arb #(
    .NCH(NCH), .COORD_W(COORD_W), .MAP_W(MAP_W), .MAP_H(MAP_H),
    .ADDR_W(ADDR_W), .TILE_W(TILE_W), .RAM_LAT(RAM_LAT),
    .KEY_W(KEY_W), .HEALTH_W(HEALTH_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .cur_x(cur_x), .cur_y(cur_y),
    .key_num(key_num), .health(health),
    .resp_valid(resp_valid), .resp_ch(resp_ch), .resp_accept(resp_accept),
    .resp_x(resp_x), .resp_y(resp_y), .resp_key(resp_key),
    .resp_health(resp_health),
    .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .ram_we(ram_we), .ram_wdata(ram_wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---- behavioural map BRAM (RAM_LAT read pipeline) with a bench poke port
  logic              poke_en = 1'b0;
  logic [7:0]        poke_addr = '0;
  logic [TILE_W-1:0] poke_data = '0;
  logic [TILE_W-1:0] mem [MAP_W*MAP_H] = '{default: '0};
  logic [TILE_W-1:0] rd_pipe [RAM_LAT];

  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
    rd_pipe[0] <= mem[ram_addr[7:0]];
    for (int i = 1; i < RAM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_rdata = rd_pipe[RAM_LAT-1];

  // ---- reference model: request queue, shadow map, grant pointer
  typedef struct {
    int ch, cx, cy, tx, ty, key, hp, due;
    bit oob;
  } req_t;

  req_t q[$];
  req_t r;
  int   shadow [MAP_W*MAP_H] = '{default: 0};
  int   last_gnt = 0, next_free = 0, exp_addr = 0;
  int   m_tile, m_key, m_hp, m_new, m_addr;
  bit   m_acc, m_we;
  logic [NCH-1:0] exp_rdy;

  function automatic void model_resolve(input int tile, input int k, input int h,
                                        output bit acc, output int nk,
                                        output int nh, output int nt);
    acc = 1'b0; nk = k; nh = h; nt = tile;
    case (tile)
      0: acc = 1'b1;
      2: begin acc = 1'b1; nk = (k + 1 > KEY_MAX) ? KEY_MAX : k + 1; nt = 0; end
      3: if (k > 0) begin acc = 1'b1; nk = k - 1; nt = 0; end
      4: begin acc = 1'b1; nh = (h + 20 > HP_MAX) ? HP_MAX : h + 20; nt = 0; end
      default: ;
    endcase
  endfunction

  always @(negedge clk) begin
    if (poke_en) shadow[poke_addr] = int'(poke_data);
    if (rst) begin
      check("reset_outputs", 64'({resp_valid, resp_ch, resp_accept, resp_x, resp_y,
                                  resp_key, resp_health, ram_we, req_ready}), 64'(0));
      check("reset_addr_wdata", 64'({ram_addr, ram_wdata}), 64'(0));
      q.delete();
      last_gnt = 0; next_free = 0; exp_addr = 0;
    end else begin
      check("ram_addr_hold", 64'(ram_addr), 64'(exp_addr));
      exp_rdy = '0;
      if (cyc >= next_free)
        for (int i = 1; i <= NCH; i++)
          if (exp_rdy == '0 && req_valid[(last_gnt + i) % NCH])
            exp_rdy[(last_gnt + i) % NCH] = 1'b1;
      check("grant", 64'(req_ready), 64'(exp_rdy));
      for (int c = 0; c < NCH; c++) begin
        if (exp_rdy[c]) begin
          r.ch  = c;
          r.cx  = int'(cur_x[c*COORD_W +: COORD_W]);
          r.cy  = int'(cur_y[c*COORD_W +: COORD_W]);
          r.tx  = int'(req_x[c*COORD_W +: COORD_W]);
          r.ty  = int'(req_y[c*COORD_W +: COORD_W]);
          r.key = int'(key_num[c*KEY_W +: KEY_W]);
          r.hp  = int'(health[c*HEALTH_W +: HEALTH_W]);
`ifdef TILE_INTERACT_BOUNDS_CHECK_EN
          r.oob = (r.tx >= MAP_W) || (r.ty >= MAP_H);
`else
          r.oob = 1'b0;
`endif
          r.due = cyc + (r.oob ? 2 : RAM_LAT + 3);
          q.push_back(r);
          last_gnt  = c;
          next_free = r.due + 1;
          if (!r.oob) exp_addr = r.ty * MAP_W + r.tx;
        end
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        r = q.pop_front();
        m_addr = r.ty * MAP_W + r.tx;
        if (r.oob) begin
          m_acc = 1'b0; m_key = r.key; m_hp = r.hp; m_we = 1'b0; m_new = 0;
        end else begin
          m_tile = shadow[m_addr % (MAP_W*MAP_H)];
          model_resolve(m_tile, r.key, r.hp, m_acc, m_key, m_hp, m_new);
          m_we = m_acc && (m_new != m_tile);
        end
        check("resp_valid", 64'(resp_valid), 64'(1));
        check("resp_ch", 64'(resp_ch), 64'(r.ch));
        check("resp_accept", 64'(resp_accept), 64'(m_acc));
        check("resp_x", 64'(resp_x), 64'(m_acc ? r.tx : r.cx));
        check("resp_y", 64'(resp_y), 64'(m_acc ? r.ty : r.cy));
        check("resp_key", 64'(resp_key), 64'(m_key));
        check("resp_health", 64'(resp_health), 64'(m_hp));
        check("ram_we", 64'(ram_we), 64'(m_we));
        if (m_we) begin
          check("ram_wdata", 64'(ram_wdata), 64'(m_new));
          shadow[m_addr % (MAP_W*MAP_H)] = m_new;
        end
      end else begin
        check("quiet_outputs", 64'({resp_valid, ram_we}), 64'(0));
      end
    end
  end

  // ---- stimulus helpers
  int hs_cyc, r_cyc;
  logic r_acc, r_we;
  logic [0:0] r_ch;
  logic [COORD_W-1:0] r_x, r_y;
  logic [KEY_W-1:0] r_key;
  logic [HEALTH_W-1:0] r_hp;
  logic [ADDR_W-1:0] r_addr;
  logic [TILE_W-1:0] r_wdata;

  task automatic poke(input int a, input int d);
    poke_addr = 8'(a); poke_data = TILE_W'(d); poke_en = 1'b1;
    @(posedge clk); #1 poke_en = 1'b0;
  endtask

  task automatic set_ch(input int ch, input int cx, input int cy, input int tx,
                        input int ty, input int k, input int h);
    cur_x[ch*COORD_W +: COORD_W]   = COORD_W'(cx);
    cur_y[ch*COORD_W +: COORD_W]   = COORD_W'(cy);
    req_x[ch*COORD_W +: COORD_W]   = COORD_W'(tx);
    req_y[ch*COORD_W +: COORD_W]   = COORD_W'(ty);
    key_num[ch*KEY_W +: KEY_W]     = KEY_W'(k);
    health[ch*HEALTH_W +: HEALTH_W] = HEALTH_W'(h);
  endtask

  // Raise valid, wait (bounded) for the grant, drop valid after the edge.
  task automatic send(input int ch);
    bit got = 1'b0;
    req_valid[ch] = 1'b1;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (req_ready[ch]) begin got = 1'b1; hs_cyc = cyc; end
    end
    if (!got) check("handshake_timeout", 64'(0), 64'(1));
    @(posedge clk); #1 req_valid[ch] = 1'b0;
  endtask

  task automatic wait_resp();
    bit got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1; r_cyc = cyc;
        r_ch = resp_ch; r_acc = resp_accept; r_x = resp_x; r_y = resp_y;
        r_key = resp_key; r_hp = resp_health; r_we = ram_we;
        r_addr = ram_addr; r_wdata = ram_wdata;
      end
    end
    if (!got) check("response_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    int seen;
    logic [3:0] seq;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Floor walk: latency and no write
    set_ch(0, 2, 2, 3, 2, 0, 100);
    send(0); wait_resp();
    check("floor_latency", 64'(r_cyc - hs_cyc), 64'(4));
    check("floor_ch", 64'(r_ch), 64'(0));
    check("floor_accept", 64'(r_acc), 64'(1));
    check("floor_pos", 64'({r_x, r_y}), 64'({4'd3, 4'd2}));
    check("floor_no_we", 64'(r_we), 64'(0));

    // Key pickup
    @(posedge clk); #1 poke(35, 2);
    set_ch(0, 2, 2, 3, 2, 1, 100);
    send(0); wait_resp();
    check("key_count", 64'(r_key), 64'(2));
    check("key_we", 64'(r_we), 64'(1));
    check("key_addr", 64'(r_addr), 64'(35));
    check("key_wdata", 64'(r_wdata), 64'(0));

    // Door without then with a key
    @(posedge clk); #1 poke(35, 3);
    set_ch(0, 2, 2, 3, 2, 0, 100);
    send(0); wait_resp();
    check("door_locked_accept", 64'(r_acc), 64'(0));
    check("door_locked_pos", 64'({r_x, r_y}), 64'({4'd2, 4'd2}));
    check("door_locked_we", 64'(r_we), 64'(0));
    set_ch(0, 2, 2, 3, 2, 1, 100);
    @(posedge clk); #1;
    send(0); wait_resp();
    check("door_open_accept", 64'(r_acc), 64'(1));
    check("door_open_key", 64'(r_key), 64'(0));
    check("door_open_wdata", 64'({r_we, r_wdata}), 64'({1'b1, 16'd0}));

    // Potion saturating at 255
    @(posedge clk); #1 poke(35, 4);
    set_ch(0, 2, 2, 3, 2, 0, 250);
    send(0); wait_resp();
    check("potion_health", 64'(r_hp), 64'(255));

    // Key count saturating at 15 still consumes the key tile
    @(posedge clk); #1 poke(20, 2);
    set_ch(0, 4, 2, 4, 1, 15, 10);
    send(0); wait_resp();
    check("key_sat", 64'({r_key, r_we}), 64'({4'd15, 1'b1}));

    // Unknown tile id rejects
    @(posedge clk); #1 poke(33, 7);
    set_ch(0, 2, 2, 1, 2, 3, 10);
    send(0); wait_resp();
    check("unknown_reject", 64'({r_acc, r_we, r_x}), 64'({1'b0, 1'b0, 4'd2}));

    // Wall on channel 1
    @(posedge clk); #1 poke(50, 1);
    set_ch(1, 2, 2, 2, 3, 0, 10);
    send(1); wait_resp();
    check("wall_ch", 64'(r_ch), 64'(1));
    check("wall_reject", 64'({r_acc, r_x, r_y}), 64'({1'b0, 4'd2, 4'd2}));

    // Both channels held valid: grants alternate starting at 0
    set_ch(0, 2, 2, 3, 2, 0, 10);
    set_ch(1, 5, 5, 6, 5, 0, 10);
    @(posedge clk); #1 req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_resp();
      seq[i] = r_ch[0];
      check("alt_dest_x", 64'(r_x), 64'(r_ch[0] ? 6 : 3));
    end
    @(posedge clk); #1 req_valid = 2'b00;
    check("alt_sequence", 64'(seq), 64'(4'b1010));

    // Reset while waiting on the RAM aborts the request
    @(posedge clk); #1 poke(68, 2);
    set_ch(0, 4, 3, 4, 4, 3, 10);
    send(0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_resp_zero", 64'({resp_valid, ram_we, ram_addr}), 64'(0));
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid || ram_we) seen++;
    end
    check("abort_no_resp", 64'(seen), 64'(0));
    check("abort_tile_kept", 64'(mem[68]), 64'(2));
    @(posedge clk); #1;
    send(0); wait_resp();
    check("after_reset_key", 64'({r_acc, r_key, r_we}), 64'({1'b1, 4'd4, 1'b1}));
    check("after_reset_addr", 64'(r_addr), 64'(68));

    repeat (6) @(posedge clk);
    check("model_drained", 64'(q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tile_interact_arb.md
# tile_interact_arb

Multi-channel tile-interaction engine for the grid game. It arbitrates move requests from NCH actors (player plus monsters/NPCs) round-robin and reads the target tile from the map BRAM. It resolves the interaction (walk, wall, key, door, potion), writes the changed tile back, and returns one response per request. It sits between the actor controllers and the map BRAM port, and is the multi-actor, parametrised successor of the single-player interaction block.

## Interface
- NCH, 2, number of request channels (≥1)
- COORD_W, 4, coordinate width
- MAP_W / MAP_H, 16 / 16, map dimensions in tiles
- ADDR_W, 19, map BRAM address width
- TILE_W, 16, tile id width
- RAM_LAT, 1, BRAM read latency in cycles (≥1)
- KEY_W / HEALTH_W, 4 / 8, key-count and health widths
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NCH  per-channel move request
- req_ready  out  NCH  one-hot grant; handshake = valid & ready
- req_x, req_y  in  NCH*COORD_W  packed target coordinates
- cur_x, cur_y  in  NCH*COORD_W  packed current positions
- key_num  in  NCH*KEY_W  packed key counts
- health  in  NCH*HEALTH_W  packed health values
- resp_valid  out  1  one-cycle response strobe
- resp_ch  out  $clog2(NCH) (min 1)  channel answered
- resp_accept  out  1  move allowed
- resp_x, resp_y  out  COORD_W  resulting position (target if accepted, else current)
- resp_key  out  KEY_W  updated key count
- resp_health  out  HEALTH_W  updated health
- ram_addr  out  ADDR_W  map address
- ram_rdata  in  TILE_W  map read data
- ram_we  out  1  one-cycle write strobe
- ram_wdata  out  TILE_W  tile written back

## Operation
- States: IDLE → WAIT → CAPTURE → COMMIT → IDLE.
- IDLE: the round-robin grant picks the first valid channel after the last-granted one, and req_ready drives only that bit. On handshake, the request is latched (channel, target, current position, key, health) and ram_addr is registered as req_y*MAP_W + req_x, computed at ADDR_W width with no truncation.
- WAIT: lasts RAM_LAT cycles, counted by a down-counter.
- CAPTURE: latches ram_rdata into tile_q.
- COMMIT: the resolver evaluates; all resp_* and ram_we/ram_wdata are registered for one cycle. The round-robin pointer advances to the served channel.
- Resolver rules:
  - FLOOR: accept.
  - WALL: reject.
  - KEY: accept, key+1 (saturating at max), tile→FLOOR.
  - DOOR: if key>0 accept, key−1, tile→FLOOR; else reject.
  - POTION: accept, health+POTION_HEAL (saturating at 2^HEALTH_W−1), tile→FLOOR.
  - Unknown id: reject.
- ram_we asserts only when the new tile differs from tile_q. A rejected move never writes.
- Reset values: all outputs 0, state IDLE, RR pointer at channel 0.
- Reset mid-operation: returns to IDLE immediately; no write or response is emitted for the aborted request.
- req_valid dropped before the grant: no effect. Once granted, the request completes regardless of later inputs.

## Timing
- Handshake in cycle N → resp_valid/ram_we high in cycle N+RAM_LAT+3, for exactly 1 cycle.
- req_ready is 0 from N+1 until the cycle after resp_valid.
- Sustained throughput: one request per RAM_LAT+4 cycles.
- ram_addr holds its value until the next handshake.

## Configuration
- TILE_INTERACT_BOUNDS_CHECK_EN defined:
  - A request with req_x≥MAP_W or req_y≥MAP_H goes IDLE→COMMIT directly.
  - Response: resp_accept=0, position = current, resp at N+2.
  - ram_addr stays unchanged and there is no RAM access.
- Undefined: the address is computed unchecked and the request follows the normal path.

## Structure
- Shared package tile_interact_pkg holds:
  - Tile codes: TILE_FLOOR=0, TILE_WALL=1, TILE_KEY=2, TILE_DOOR=3, TILE_POTION=4.
  - POTION_HEAL=20.
  - State encodings.
- One combinational sub-module, tile_rule_resolve. Inputs: tile, position, key, health. Outputs: accept, goto, key, health, new tile. It is shared by all channels.

## Test plan
- ch0 cur (2,2) req (3,2), RAM[35]=FLOOR, RAM_LAT=1 → resp at N+4: ch0, accept=1, (3,2); ram_we never asserts.
- ch0 req onto RAM[35]=KEY with key=1 → resp_key=2, ram_we=1, ram_addr=35, ram_wdata=0.
- DOOR with key=0 → accept=0, resp=(2,2), no write. Repeat with key=1 → accept=1, key=0, write 0.
- ch0 and ch1 valid continuously → grants alternate 0,1,0,1; each response matches its channel.
- POTION with health=250 → resp_health=255. With macro on, req (16,0) → accept=0 at N+2, no ram_we.
- rst asserted during WAIT → all outputs 0 next cycle; no resp_valid/ram_we for that request; a fresh request afterwards completes normally.
